// File: rtl/rm_pkg.sv
// Shared types and default sizing for the runtime-monitor lane.
package rm_pkg;

    localparam int unsigned RM_NUM_EVENTS        = 10;
    localparam int unsigned RM_NUM_MONITORED_INS = 2;
    localparam int unsigned RM_RULES_PER_INS     = 5;
    localparam int unsigned RM_WINDOW_W          = 4;
    localparam int unsigned RM_NUM_RULES         = RM_NUM_MONITORED_INS * RM_RULES_PER_INS;
    localparam int unsigned RM_EVT_IDX_W         = $clog2(RM_NUM_EVENTS);
    localparam int unsigned RM_RULE_IDX_W        = $clog2(RM_NUM_RULES);

    typedef enum logic {
        RM_IDLE    = 1'b0,
        RM_PENDING = 1'b1
    } rm_rule_state_e;

    typedef struct packed {
        logic                    en;
        logic [RM_EVT_IDX_W-1:0] trig;
        logic [RM_EVT_IDX_W-1:0] resp;
        logic [RM_WINDOW_W-1:0]  window;
    } rm_rule_cfg_t;

endpackage

// File: rtl/rm_lane_mon_if.sv
// Violation-report stream between a monitor lane and the RM collector.
interface rm_lane_mon_if #(
    parameter int unsigned RULE_IDX_W = rm_pkg::RM_RULE_IDX_W
) ();

    logic                  rpt_valid_o;
    logic                  rpt_ready_i;
    logic [RULE_IDX_W-1:0] rpt_rule_o;
    logic                  rpt_ovf_o;

    modport master (
        output rpt_valid_o,
        output rpt_rule_o,
        output rpt_ovf_o,
        input  rpt_ready_i
    );

    modport slave (
        input  rpt_valid_o,
        input  rpt_rule_o,
        input  rpt_ovf_o,
        output rpt_ready_i
    );

endinterface

// File: rtl/rm_rule_checker.sv
// One bounded-response rule: trigger must be followed by response within cfg.window beats.
module rm_rule_checker
    import rm_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         beat,
    input  logic         trig,
    input  logic         resp,
    input  rm_rule_cfg_t cfg,
    input  logic         clr,
    input  logic         load,
    output logic         busy,
    output logic         viol_c
);

    rm_rule_state_e         state_q, state_d;
    logic [RM_WINDOW_W-1:0] cnt_q, cnt_d;

    // Event selection happens in the parent; only enable and window matter here.
    logic unused_cfg;
    assign unused_cfg = ^{cfg.trig, cfg.resp};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RM_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == RM_PENDING);
        end
    end

    // Clear and reconfiguration both abort any check in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        viol_c  = 1'b0;
        if (clr || load) begin
            state_d = RM_IDLE;
            cnt_d   = '0;
        end else if (beat) begin
            case (state_q)
                RM_IDLE: begin
                    if (cfg.en && trig && !resp) begin
                        if (cfg.window == '0) begin
                            viol_c = 1'b1;
                        end else begin
                            state_d = RM_PENDING;
                            cnt_d   = cfg.window;
                        end
                    end
                end
                RM_PENDING: begin
                    if (resp) begin
                        state_d = RM_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == RM_WINDOW_W'(1)) begin
                        viol_c  = 1'b1;
                        state_d = RM_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - RM_WINDOW_W'(1);
                    end
                end
                default: begin
                    state_d = RM_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rm_lane_mon.sv
// Runtime-monitor lane: programmable bounded-response rules with sticky flags and a report stream.
module rm_lane_mon
    import rm_pkg::*;
#(
    parameter  int unsigned NUM_EVENTS        = RM_NUM_EVENTS,
    parameter  int unsigned NUM_MONITORED_INS = RM_NUM_MONITORED_INS,
    parameter  int unsigned RULES_PER_INS     = RM_RULES_PER_INS,
    parameter  int unsigned WINDOW_W          = RM_WINDOW_W,
    localparam int unsigned NUM_RULES         = NUM_MONITORED_INS * RULES_PER_INS,
    localparam int unsigned EVT_IDX_W         = $clog2(NUM_EVENTS),
    localparam int unsigned RULE_IDX_W        = $clog2(NUM_RULES)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        lane_clear_i,
    input  logic                                        lane_valid_i,
    input  logic [NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0] lane_vector_i,
    input  logic                                        cfg_we_i,
    input  logic [RULE_IDX_W-1:0]                       cfg_idx_i,
    input  logic                                        cfg_en_i,
    input  logic [EVT_IDX_W-1:0]                        cfg_trig_i,
    input  logic [EVT_IDX_W-1:0]                        cfg_resp_i,
    input  logic [WINDOW_W-1:0]                         cfg_window_i,
    output logic [NUM_RULES-1:0]                        monitor_o,
    output logic [NUM_RULES-1:0]                        busy_o,
    rm_lane_mon_if.master                               rpt
);

    rm_rule_cfg_t          cfg_q [NUM_RULES];
    logic                  cfg_wr_c;
    logic [NUM_RULES-1:0]  viol_c;
    logic [NUM_RULES-1:0]  pend_q;
    logic [NUM_RULES-1:0]  lowest_c;
    logic [NUM_RULES-1:0]  pop_c;
    logic [RULE_IDX_W-1:0] rule_c;
    logic                  ovf_q;

    assign cfg_wr_c = cfg_we_i && !lane_clear_i &&
                      ({1'b0, cfg_idx_i} < (RULE_IDX_W+1)'(NUM_RULES));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < NUM_RULES; r++) begin
                cfg_q[r] <= '0;
            end
        end else if (cfg_wr_c) begin
            cfg_q[cfg_idx_i] <= '{en: cfg_en_i, trig: cfg_trig_i,
                                  resp: cfg_resp_i, window: cfg_window_i};
        end
    end

    for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
        localparam int unsigned SLOT = r / RULES_PER_INS;
        logic trig_c, resp_c, load_c;

        // Out-of-range event indices select a constant 0.
        assign trig_c = ({1'b0, cfg_q[r].trig} < (EVT_IDX_W+1)'(NUM_EVENTS)) ?
                        lane_vector_i[SLOT][cfg_q[r].trig] : 1'b0;
        assign resp_c = ({1'b0, cfg_q[r].resp} < (EVT_IDX_W+1)'(NUM_EVENTS)) ?
                        lane_vector_i[SLOT][cfg_q[r].resp] : 1'b0;
        assign load_c = cfg_wr_c && (cfg_idx_i == RULE_IDX_W'(r));

        rm_rule_checker u_chk (
            .clk    (clk_i),
            .rst_n  (rst_ni),
            .beat   (lane_valid_i),
            .trig   (trig_c),
            .resp   (resp_c),
            .cfg    (cfg_q[r]),
            .clr    (lane_clear_i),
            .load   (load_c),
            .busy   (busy_o[r]),
            .viol_c (viol_c[r])
        );
    end

    // Lowest pending rule is presented; a handshake pops exactly that bit.
    assign lowest_c = pend_q & (~pend_q + NUM_RULES'(1));
    assign pop_c    = rpt.rpt_ready_i ? lowest_c : '0;

    always_comb begin
        rule_c = '0;
        for (int unsigned i = NUM_RULES; i > 0; i--) begin
            if (pend_q[i-1]) rule_c = RULE_IDX_W'(i-1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            monitor_o <= '0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (lane_clear_i) begin
            monitor_o <= '0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            monitor_o <= monitor_o | viol_c;
            pend_q    <= (pend_q & ~pop_c) | viol_c;
            if (|(viol_c & pend_q & ~pop_c)) ovf_q <= 1'b1;
        end
    end

    assign rpt.rpt_valid_o = |pend_q;
    assign rpt.rpt_rule_o  = rule_c;
    assign rpt.rpt_ovf_o   = ovf_q;

endmodule

// File: tb/tb_rm_lane_mon.sv
// Directed bench for rm_lane_mon with a report scoreboard checked by an independent monitor.
module tb_rm_lane_mon;
    import rm_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lane_clear = 1'b0;
    logic             lane_valid = 1'b0;
    logic [1:0][9:0]  lane_vector = '0;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_idx = '0;
    logic             cfg_en = 1'b0;
    logic [3:0]       cfg_trig = '0;
    logic [3:0]       cfg_resp = '0;
    logic [3:0]       cfg_window = '0;
    logic [9:0]       monitor;
    logic [9:0]       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    rm_lane_mon_if #(.RULE_IDX_W(4)) rpt_if ();

    rm_lane_mon dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .lane_clear_i  (lane_clear),
        .lane_valid_i  (lane_valid),
        .lane_vector_i (lane_vector),
        .cfg_we_i      (cfg_we),
        .cfg_idx_i     (cfg_idx),
        .cfg_en_i      (cfg_en),
        .cfg_trig_i    (cfg_trig),
        .cfg_resp_i    (cfg_resp),
        .cfg_window_i  (cfg_window),
        .monitor_o     (monitor),
        .busy_o        (busy),
        .rpt           (rpt_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Every accepted report is matched against the next expected rule index.
    always @(negedge clk) begin
        int e;
        if (rst_n && rpt_if.rpt_valid_o === 1'b1 && rpt_if.rpt_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rpt_unexpected: got rule %0d, required no report", rpt_if.rpt_rule_o);
            end else begin
                e = exp_q.pop_front();
                chk("rpt_rule_popped", 32'(rpt_if.rpt_rule_o), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic valid, input logic [9:0] ev0, input logic [9:0] ev1);
        lane_valid     = valid;
        lane_vector[0] = ev0;
        lane_vector[1] = ev1;
        step();
        lane_valid  = 1'b0;
        lane_vector = '0;
    endtask

    task automatic cfg_wr(input logic [3:0] idx, input logic en, input logic [3:0] trig,
                          input logic [3:0] resp, input logic [3:0] win);
        cfg_we     = 1'b1;
        cfg_idx    = idx;
        cfg_en     = en;
        cfg_trig   = trig;
        cfg_resp   = resp;
        cfg_window = win;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pop();
        rpt_if.rpt_ready_i = 1'b1;
        step();
        rpt_if.rpt_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rpt_if.rpt_ready_i = 1'b0;
        step();
        chk("reset_monitor", 32'(monitor), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_valid", 32'(rpt_if.rpt_valid_o), 32'h0);
        chk("reset_ovf", 32'(rpt_if.rpt_ovf_o), 32'h0);
        rst_n = 1'b1;
        step();

        // Rule 0: trig=4, resp=5, window=3; response on the third beat after trigger.
        cfg_wr(4'd0, 1'b1, 4'd4, 4'd5, 4'd3);
        cyc(1'b1, 10'h010, 10'h0);
        chk("t1_busy_after_trig", 32'(busy), 32'h001);
        cyc(1'b1, 10'h0, 10'h0);
        cyc(1'b1, 10'h0, 10'h0);
        chk("t1_busy_beat2", 32'(busy), 32'h001);
        cyc(1'b1, 10'h020, 10'h0);
        chk("t1_busy_after_resp", 32'(busy), 32'h0);
        chk("t1_no_violation", 32'(monitor), 32'h0);
        chk("t1_no_report", 32'(rpt_if.rpt_valid_o), 32'h0);

        // Same rule, no response: violation on the third beat.
        cyc(1'b1, 10'h010, 10'h0);
        cyc(1'b1, 10'h0, 10'h0);
        cyc(1'b1, 10'h0, 10'h0);
        chk("t2_before_expiry", 32'(monitor), 32'h0);
        exp_q.push_back(0);
        cyc(1'b1, 10'h0, 10'h0);
        chk("t2_monitor", 32'(monitor), 32'h001);
        chk("t2_valid", 32'(rpt_if.rpt_valid_o), 32'h1);
        chk("t2_rule", 32'(rpt_if.rpt_rule_o), 32'h0);
        chk("t2_busy_clear", 32'(busy), 32'h0);
        pop();
        chk("t2_valid_after_pop", 32'(rpt_if.rpt_valid_o), 32'h0);

        // Gaps without lane_valid do not consume window.
        cyc(1'b1, 10'h010, 10'h0);
        cyc(1'b0, 10'h0, 10'h0);
        cyc(1'b1, 10'h0, 10'h0);
        cyc(1'b0, 10'h0, 10'h0);
        cyc(1'b1, 10'h0, 10'h0);
        cyc(1'b0, 10'h0, 10'h0);
        chk("t3_still_pending", 32'(busy), 32'h001);
        chk("t3_no_report_yet", 32'(rpt_if.rpt_valid_o), 32'h0);
        exp_q.push_back(0);
        cyc(1'b1, 10'h0, 10'h0);
        chk("t3_report", 32'(rpt_if.rpt_valid_o), 32'h1);
        pop();

        // Rules 2 (slot 0) and 7 (slot 1), window 0: simultaneous violations, then overflow on 7.
        cfg_wr(4'd2, 1'b1, 4'd0, 4'd1, 4'd0);
        cfg_wr(4'd7, 1'b1, 4'd0, 4'd1, 4'd0);
        exp_q.push_back(2);
        exp_q.push_back(7);
        cyc(1'b1, 10'h001, 10'h001);
        chk("t4_rule_first", 32'(rpt_if.rpt_rule_o), 32'h2);
        chk("t4_monitor", 32'(monitor), 32'h085);
        chk("t4_no_ovf_yet", 32'(rpt_if.rpt_ovf_o), 32'h0);
        cyc(1'b1, 10'h0, 10'h001);
        chk("t4_ovf", 32'(rpt_if.rpt_ovf_o), 32'h1);
        chk("t4_rule_stable", 32'(rpt_if.rpt_rule_o), 32'h2);
        pop();
        chk("t4_rule_second", 32'(rpt_if.rpt_rule_o), 32'h7);
        pop();
        chk("t4_drained", 32'(rpt_if.rpt_valid_o), 32'h0);

        // Trig+resp together satisfies; out-of-range trigger index never fires.
        cfg_wr(4'd3, 1'b1, 4'd12, 4'd1, 4'd0);
        cyc(1'b1, 10'h3FF, 10'h0);
        chk("t5_no_report", 32'(rpt_if.rpt_valid_o), 32'h0);
        chk("t5_monitor_kept", 32'(monitor), 32'h085);
        chk("t5_busy", 32'(busy), 32'h0);

        // Reconfiguring a pending rule aborts the check.
        cyc(1'b1, 10'h010, 10'h0);
        chk("t6_pending", 32'(busy), 32'h001);
        cfg_wr(4'd0, 1'b1, 4'd4, 4'd5, 4'd3);
        chk("t6_aborted", 32'(busy), 32'h0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 10'h0, 10'h0);
        chk("t6_no_report", 32'(rpt_if.rpt_valid_o), 32'h0);

        // Clear drops flags and overflow but keeps configuration.
        lane_clear = 1'b1;
        step();
        lane_clear = 1'b0;
        chk("t7_monitor_cleared", 32'(monitor), 32'h0);
        chk("t7_ovf_cleared", 32'(rpt_if.rpt_ovf_o), 32'h0);
        exp_q.push_back(2);
        cyc(1'b1, 10'h001, 10'h0);
        chk("t7_cfg_kept", 32'(monitor), 32'h004);
        chk("t7_rule", 32'(rpt_if.rpt_rule_o), 32'h2);

        // Violation on the rule being popped in the same cycle: re-pends, no overflow.
        exp_q.push_back(2);
        rpt_if.rpt_ready_i = 1'b1;
        cyc(1'b1, 10'h001, 10'h0);
        rpt_if.rpt_ready_i = 1'b0;
        chk("t8_repend", 32'(rpt_if.rpt_valid_o), 32'h1);
        chk("t8_no_ovf", 32'(rpt_if.rpt_ovf_o), 32'h0);
        pop();
        chk("t8_drained", 32'(rpt_if.rpt_valid_o), 32'h0);

        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
